mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, default 16, address width.
REQ-002 Parameter: DW, default 16, data width.
REQ-003 Parameter: STARVE_MAX, default 4, the number of consecutive data grants allowed while fetch waits.
REQ-004 Port: clk  in  1  system clock; all state changes on the rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: if_req  in  1  instruction-fetch request; held until if_gnt is seen.
REQ-007 Port: if_addr  in  AW  fetch address.
REQ-008 Port: if_gnt  out  1  fetch request accepted this cycle (combinational).
REQ-009 Port: if_valid  out  1  one-cycle pulse; fetch data is valid.
REQ-010 Port: if_rdata  out  DW  fetched instruction.
REQ-011 Port: d_req  in  1  data-stage request; held until d_gnt is seen.
REQ-012 Port: d_we  in  1  1 = store, 0 = load.
REQ-013 Port: d_addr  in  AW  data address.
REQ-014 Port: d_wdata  in  DW  store data.
REQ-015 Port: d_gnt  out  1  data request accepted this cycle (combinational).
REQ-016 Port: d_valid  out  1  one-cycle pulse; load data is valid, or store is complete.
REQ-017 Port: d_rdata  out  DW  load data.
REQ-018 Port: mem_en  out  1  memory access active (registered).
REQ-019 Port: mem_we  out  1  memory write strobe (registered).
REQ-020 Port: mem_addr  out  AW  memory address (registered).
REQ-021 Port: mem_wdata  out  DW  memory write data (registered).
REQ-022 Port: mem_rdata  in  DW  memory read data; sampled when mem_ready is 1.
REQ-023 Port: mem_ready  in  1  memory has completed the current access.
REQ-024 Port: flush  in  1  branch or jump taken; discard the in-flight fetch.
REQ-025 Port: pc_hold  out  1  stall the PC (combinational).

Function
REQ-026 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-027 A grant SHALL be possible only in IDLE, or in the completing cycle of BUSY_x (the cycle where mem_ready is 1), so that back-to-back accesses are supported.
REQ-028 Priority rules:
- Data SHALL win when d_req and if_req are both asserted.
- Exception: when starve_cnt equals STARVE_MAX, fetch SHALL win.
REQ-029 At most one of if_gnt and d_gnt SHALL be 1 in any cycle.
REQ-030 On a grant in cycle N:
- Address, we and wdata SHALL be registered onto the mem_* outputs.
- mem_en SHALL be 1 from cycle N+1.
- The state SHALL become BUSY_I or BUSY_D.
REQ-031 In BUSY_x, the mem_* outputs SHALL be held stable until a cycle M in which mem_ready is 1.
REQ-032 In cycle M+1, the completion SHALL appear:
- The matching *_valid SHALL pulse for 1 cycle.
- The matching *_rdata SHALL hold the mem_rdata value captured in cycle M.
- *_rdata SHALL otherwise hold its last value.
REQ-033 If no grant occurs in cycle M, mem_en SHALL be 0 from M+1 and the state SHALL return to IDLE.
REQ-034 For a store, mem_we SHALL be 1 for the whole access; d_valid SHALL pulse at completion and d_rdata SHALL be unchanged.
REQ-035 Minimum latency, grant to valid, SHALL be 2 cycles (with mem_ready=1 in the first BUSY cycle).
REQ-036 Starvation counter starve_cnt:
- It SHALL increment on each d_gnt issued while if_req is 1.
- It SHALL clear on if_gnt.
- It SHALL saturate at STARVE_MAX.
- It SHALL hold otherwise.
REQ-037 pc_hold SHALL equal if_req AND NOT if_gnt.
REQ-038 Flush during a fetch:
- A flush in any cycle while BUSY_I, or in the BUSY_I completing cycle, SHALL mark the fetch as squashed.
- The memory access SHALL still complete.
- if_valid SHALL be suppressed for that fetch.
REQ-039 Flush SHALL have no effect in IDLE or BUSY_D; the squash mark SHALL clear at completion.
REQ-040 Requests SHALL NOT be aborted: mem_en SHALL stay 1 until mem_ready, with no timeout.

Reset
REQ-041 While rst is 0, asynchronously, the following SHALL hold:
- State = IDLE.
- mem_en = mem_we = 0.
- mem_addr = mem_wdata = 0.
- if_valid = d_valid = 0.
- if_rdata = d_rdata = 0.
- starve_cnt = 0.
- Squash mark = 0.
REQ-042 Reset asserted mid-access SHALL drop mem_en immediately; no valid SHALL be generated for the aborted access after release.
REQ-043 No grant SHALL be issued in any cycle in which rst is 0.

Verification
REQ-044 Single load: d_req=1, d_we=0, d_addr=0x0010; memory returns 0xBEEF with mem_ready=1 one cycle later -> d_gnt in cycle 0, mem_en cycles 1..1, d_valid in cycle 2 with d_rdata=0xBEEF.
REQ-045 Conflict: if_req and d_req both asserted continuously, mem_ready always 1, STARVE_MAX=4 -> grant order D,D,D,D,I,D,...; pc_hold=1 on every cycle without if_gnt.
REQ-046 Wait states: fetch at 0x0100, mem_ready low for 3 cycles -> mem_en/mem_addr stable for 4 cycles; if_valid pulses exactly once.
REQ-047 Flush: fetch granted, flush=1 in the first BUSY_I cycle -> no if_valid; the next fetch at the new address is granted in the completing cycle.
REQ-048 Reset mid-access: rst=0 during BUSY_D -> mem_en=0 in the same cycle; after rst=1 with no requests -> no d_valid, state IDLE.
REQ-049 Store: d_we=1, d_addr=0x0020, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 until mem_ready; d_valid pulses; d_rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data accesses,
// data-first with a starvation limit, plus squashing of fetches hit by a flush.
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    input  logic          flush,
    output logic          pc_hold
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          squash;
    logic          done;
    logic          can_grant;
    logic          fetch_first;
    logic          if_done;
    always_comb begin
        done        = state != IDLE && mem_ready;
        can_grant   = rst && (state == IDLE || mem_ready);
        fetch_first = starve_cnt == SW'(STARVE_MAX);
        d_gnt       = can_grant && d_req && !(if_req && fetch_first);
        if_gnt      = can_grant && if_req && !d_gnt;
        pc_hold     = if_req && !if_gnt;
        if_done     = done && state == BUSY_I && !(squash || flush);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            starve_cnt <= '0;
            squash     <= 1'b0;
        end else begin
            if_valid <= if_done;
            d_valid  <= done && state == BUSY_D;
            if (if_done)
                if_rdata <= mem_rdata;
            if (done && state == BUSY_D && !mem_we)
                d_rdata <= mem_rdata;
            // squash survives until the fetch completes, then clears for the next one
            squash <= state == BUSY_I && !done && (squash || flush);
            if (if_gnt)
                starve_cnt <= '0;
            else if (d_gnt && if_req && !fetch_first)
                starve_cnt <= starve_cnt + 1'b1;
            if (d_gnt || if_gnt) begin
                state    <= d_gnt ? BUSY_D : BUSY_I;
                mem_en   <= 1'b1;
                mem_we   <= d_gnt && d_we;
                mem_addr <= d_gnt ? d_addr : if_addr;
                if (d_gnt)
                    mem_wdata <= d_wdata;
            end else if (done) begin
                state  <= IDLE;
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random scenarios for mem_arbiter, with a
// cycle-level reference model and data scoreboard running alongside.
module tb_mem_arbiter;
    localparam int SM = 4;
    logic        clk = 1'b0, rst = 1'b0;
    logic        if_req = 1'b0, if_gnt, if_valid;
    logic [15:0] if_addr = '0, if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_valid;
    logic [15:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic        mem_en, mem_we, mem_ready, flush = 1'b0, pc_hold;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    int checks = 0, errors = 0;
    int ws = 0, busy_cnt = 0;

    mem_arbiter #(.AW(16), .DW(16), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .flush(flush), .pc_hold(pc_hold)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a == 16'h0010 ? 16'hBEEF : a ^ 16'h5A5A;
    endfunction

    // memory model: ready after ws wait cycles, read data derived from the address
    assign mem_ready = mem_en && busy_cnt >= ws;
    assign mem_rdata = mem_val(mem_addr);
    always @(posedge clk) busy_cnt <= (mem_en && !mem_ready) ? busy_cnt + 1 : 0;

    logic [15:0] iq[$], dq[$];
    int          m_busy = 0, m_s = 0;
    logic        m_sq = 1'b0, m_we = 1'b0, exp_iv = 1'b0, exp_dv = 1'b0;
    logic [15:0] m_addr = '0, m_wd = '0, m_drd = '0;

    always @(negedge clk) begin
        logic can, eg_d, eg_i, sq;
        logic [15:0] e;
        if (!rst) begin
            iq.delete(); dq.delete();
            m_busy = 0; m_s = 0; m_sq = 0; m_drd = '0; exp_iv = 0; exp_dv = 0;
            checks++;
            if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet: if_gnt=%b d_gnt=%b mem_en=%b required 0 0 0", if_gnt, d_gnt, mem_en);
            end
        end else begin
            checks++;
            if (if_valid !== exp_iv) begin errors++; $display("FAIL if_valid_timing: got %b required %b", if_valid, exp_iv); end
            checks++;
            if (d_valid !== exp_dv) begin errors++; $display("FAIL d_valid_timing: got %b required %b", d_valid, exp_dv); end
            if (if_valid === 1'b1 && iq.size() > 0) begin
                e = iq.pop_front();
                checks++;
                if (if_rdata !== e) begin errors++; $display("FAIL if_rdata_sb: got %h required %h", if_rdata, e); end
            end
            if (d_valid === 1'b1 && dq.size() > 0) begin
                e = dq.pop_front();
                checks++;
                if (d_rdata !== e) begin errors++; $display("FAIL d_rdata_sb: got %h required %h", d_rdata, e); end
            end
            can  = m_busy == 0 || mem_ready;
            eg_d = can && d_req && !(if_req && m_s == SM);
            eg_i = can && if_req && !eg_d;
            checks++;
            if ({if_gnt, d_gnt} !== {eg_i, eg_d}) begin
                errors++;
                $display("FAIL grant: if_gnt/d_gnt got %b%b required %b%b", if_gnt, d_gnt, eg_i, eg_d);
            end
            checks++;
            if (pc_hold !== (if_req && !eg_i)) begin errors++; $display("FAIL pc_hold: got %b required %b", pc_hold, if_req && !eg_i); end
            checks++;
            if (mem_en !== (m_busy != 0)) begin errors++; $display("FAIL mem_en: got %b required %b", mem_en, m_busy != 0); end
            if (m_busy != 0) begin
                checks++;
                if (mem_addr !== m_addr || mem_we !== m_we || (m_we && mem_wdata !== m_wd)) begin
                    errors++;
                    $display("FAIL mem_hold: addr/we/wdata got %h/%b/%h required %h/%b/%h", mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wd);
                end
            end
            sq     = m_sq || flush;
            exp_iv = m_busy == 1 && mem_ready && !sq;
            exp_dv = m_busy == 2 && mem_ready;
            if (exp_iv) iq.push_back(mem_val(m_addr));
            if (exp_dv) begin
                if (!m_we) m_drd = mem_val(m_addr);
                dq.push_back(m_drd);
            end
            m_sq = m_busy == 1 && !mem_ready && sq;
            if (eg_i) m_s = 0;
            else if (eg_d && if_req && m_s < SM) m_s++;
            if (eg_i) begin m_busy = 1; m_addr = if_addr; m_we = 0; end
            else if (eg_d) begin m_busy = 2; m_addr = d_addr; m_we = d_we; m_wd = d_wdata; end
            else if (m_busy != 0 && mem_ready) m_busy = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL reset_no_grant: got %b%b required 00", if_gnt, d_gnt); end
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== 34'h0) begin
            errors++; $display("FAIL reset_mem: en/we/addr/wdata got %b/%b/%h/%h required 0", mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({if_valid, d_valid, if_rdata, d_rdata} !== 34'h0) begin
            errors++; $display("FAIL reset_out: valids %b%b rdata %h/%h required 0", if_valid, d_valid, if_rdata, d_rdata);
        end
        cyc();
        if_req = 1'b0; d_req = 1'b0; rst = 1'b1;
        cyc();
    endtask

    task automatic test_single_load();
        ws = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt: got %b required 1", d_gnt); end
        cyc();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0010) begin errors++; $display("FAIL load_busy: en %b addr %h required 1 0010", mem_en, mem_addr); end
        cyc();
        @(negedge clk);
        checks++;
        if (d_valid !== 1'b1 || d_rdata !== 16'hBEEF || mem_en !== 1'b0) begin
            errors++; $display("FAIL load_done: valid %b rdata %h en %b required 1 beef 0", d_valid, d_rdata, mem_en);
        end
        cyc();
    endtask

    task automatic test_store();
        ws = 2;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b required 1", d_gnt); end
        cyc();
        d_req = 1'b0; d_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0020) begin
                errors++; $display("FAIL store_hold: en %b we %b wdata %h addr %h", mem_en, mem_we, mem_wdata, mem_addr);
            end
            cyc();
        end
        @(negedge clk);
        checks++;
        if (d_valid !== 1'b1 || d_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL store_done: valid %b rdata %h required 1 beef", d_valid, d_rdata);
        end
        cyc();
        ws = 0;
    endtask

    task automatic test_conflict();
        string exp_order = "DDDDIDDDDI";
        byte   got;
        do_reset();
        ws = 0;
        if_req = 1'b1; if_addr = 16'h0200; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = if_gnt ? "I" : d_gnt ? "D" : "-";
            checks++;
            if (got !== exp_order[i]) begin errors++; $display("FAIL conflict_order[%0d]: got %c required %c", i, got, exp_order[i]); end
            checks++;
            if (pc_hold !== !if_gnt) begin errors++; $display("FAIL conflict_pc_hold[%0d]: got %b required %b", i, pc_hold, !if_gnt); end
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_wait_states();
        int nv = 0;
        ws = 3;
        if_req = 1'b1; if_addr = 16'h0100;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL wait_gnt: got %b required 1", if_gnt); end
        cyc();
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== 16'h0100) begin errors++; $display("FAIL wait_stable[%0d]: en %b addr %h required 1 0100", i, mem_en, mem_addr); end
            nv += int'(if_valid);
            cyc();
        end
        repeat (3) begin
            @(negedge clk);
            nv += int'(if_valid);
            cyc();
        end
        checks++;
        if (nv != 1) begin errors++; $display("FAIL wait_valid_count: got %0d required 1", nv); end
        ws = 0;
    endtask

    task automatic test_flush();
        int nv = 0;
        ws = 1;
        if_req = 1'b1; if_addr = 16'h0400;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_first_gnt: got %b required 1", if_gnt); end
        cyc();
        flush = 1'b1; if_addr = 16'h0500;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b0) begin errors++; $display("FAIL flush_early_gnt: got %b required 0", if_gnt); end
        cyc();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL flush_refetch_gnt: gnt %b ready %b required 1 1", if_gnt, mem_ready); end
        cyc();
        if_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            nv += int'(if_valid);
            cyc();
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL flush_squashed: if_valid count %0d required 0", nv); end
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== mem_val(16'h0500)) begin
            errors++; $display("FAIL flush_new_fetch: valid %b rdata %h required 1 %h", if_valid, if_rdata, mem_val(16'h0500));
        end
        cyc();
        ws = 0;
    endtask

    task automatic test_reset_mid();
        int nv = 0, ne = 0;
        ws = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b required 1", d_gnt); end
        cyc();
        d_req = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL rmid_async: mem_en %b required 0", mem_en); end
        cyc();
        cyc();
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            nv += int'(d_valid);
            ne += int'(mem_en);
            cyc();
        end
        checks++;
        if (nv != 0 || ne != 0) begin errors++; $display("FAIL rmid_after: d_valid count %0d mem_en count %0d required 0 0", nv, ne); end
        ws = 0;
    endtask

    task automatic test_back_to_back(input int w);
        logic gi, gd;
        ws = w;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            gi = if_gnt; gd = d_gnt;
            cyc();
            if (!if_req || gi) begin if_req = 1'($urandom_range(0, 1)); if_addr = 16'($urandom); end
            if (!d_req || gd) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            flush = $urandom_range(0, 3) == 0;
        end
        @(negedge clk);
        gi = if_gnt; gd = d_gnt;
        cyc();
        if (gi) if_req = 1'b0;
        if (gd) d_req = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 30 && (if_req || d_req); i++) begin
            @(negedge clk);
            gi = if_gnt; gd = d_gnt;
            cyc();
            if (gi) if_req = 1'b0;
            if (gd) d_req = 1'b0;
        end
        repeat (10) cyc();
        checks++;
        if (iq.size() != 0 || dq.size() != 0 || if_req || d_req) begin
            errors++; $display("FAIL b2b_drain: iq %0d dq %0d reqs %b%b required empty", iq.size(), dq.size(), if_req, d_req);
        end
        ws = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_load();
        test_store();
        test_conflict();
        test_wait_states();
        test_flush();
        test_reset_mid();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
